// File: rtl/jt49_pkg.sv
// jt49_pkg: shared widths, FIFO depth and FSM encoding for the DC-removal filter.
package jt49_pkg;
   localparam int OW = 16;
   localparam int FDEPTH = 2;
   localparam int OVW = 8;
   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/jt49_dcrm_if.sv
// jt49_dcrm_if: push/pop bundle between the filter pipeline and its output FIFO.
interface jt49_dcrm_if;
   import jt49_pkg::*;
   logic push;
   logic signed [OW-1:0] data_in;
   logic flush;
   logic ready;
   logic valid;
   logic signed [OW-1:0] data_out;
   logic drop;
   modport master(output push, data_in, flush, ready, input valid, data_out, drop);
   modport slave(input push, data_in, flush, ready, output valid, data_out, drop);
endinterface

// File: rtl/jt49_dcrm_fifo.sv
// jt49_dcrm_fifo: 2-entry output FIFO; e0 is always the oldest entry.
module jt49_dcrm_fifo
   import jt49_pkg::*;
(
   input logic clk,
   input logic rst,
   jt49_dcrm_if.slave s
);
   logic signed [OW-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0] cnt_q, cnt_d, rem;
   logic pop_ok, push_ok;
   always_comb begin
      pop_ok = s.ready & (cnt_q != 2'd0);
      push_ok = s.push & ((cnt_q != 2'(FDEPTH)) | pop_ok);
      rem = cnt_q - {1'b0, pop_ok};
      cnt_d = s.flush ? 2'd0 : rem + {1'b0, push_ok};
      e0_d = (push_ok && rem == 2'd0) ? s.data_in : pop_ok ? e1_q : e0_q;
      e1_d = (push_ok && rem == 2'd1) ? s.data_in : e1_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 2'd0;
         e0_q <= '0;
         e1_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q <= e0_d;
         e1_q <= e1_d;
      end
   end
   assign s.valid = cnt_q != 2'd0;
   assign s.data_out = s.valid ? e0_q : '0;
   // a flush discards everything anyway, so it never counts as an overflow
   assign s.drop = s.push & ~push_ok & ~s.flush;
endmodule

// File: rtl/jt49_dcrm.sv
// jt49_dcrm: PSG DC removal -- running-mean subtraction, gain, saturation, 2-deep output FIFO.
module jt49_dcrm
   import jt49_pkg::*;
#(
   parameter int SHIFT = 8,
   parameter int DW = 10
) (
   input logic clk,
   input logic rst,
   input logic [DW-1:0] din,
   input logic din_stb,
   input logic [2:0] gain,
   input logic clr,
   output logic signed [OW-1:0] dout,
   output logic dout_valid,
   input logic dout_ready,
   output logic [OVW-1:0] ovf_cnt
);
   localparam int AW = DW + SHIFT;
   localparam int YW = OW + 8;
   localparam logic signed [YW-1:0] YMAX = 32767;
   localparam logic signed [YW-1:0] YMIN = -32768;
   state_t state_q, state_d;
   logic [AW-1:0] avg_q, avg_d;
   logic signed [DW:0] d_q, d_d;
   logic v_q, v_d, take;
   logic [OVW-1:0] ovf_q, ovf_d;
   logic [DW-1:0] mean;
   logic signed [YW-1:0] wide;
   logic signed [OW-1:0] y;
   jt49_dcrm_if f();
   always_comb begin
      mean = avg_q[AW-1:SHIFT];
      take = din_stb & ~clr;
      v_d = take;
      d_d = state_q == INIT ? '0 : $signed({1'b0, din}) - $signed({1'b0, mean});
      avg_d = !take ? avg_q : state_q == INIT ? {din, {SHIFT{1'b0}}} : avg_q + AW'(din) - AW'(mean);
      state_d = clr ? INIT : take ? RUN : state_q;
      wide = YW'(d_q) <<< (5'(15 - DW) + 5'(gain));
      y = wide > YMAX ? 16'sh7fff : wide < YMIN ? 16'sh8000 : wide[OW-1:0];
      ovf_d = (f.drop && ovf_q != '1) ? ovf_q + OVW'(1) : ovf_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         avg_q <= '0;
         d_q <= '0;
         v_q <= 1'b0;
         ovf_q <= '0;
      end else begin
         state_q <= state_d;
         avg_q <= avg_d;
         d_q <= d_d;
         v_q <= v_d;
         ovf_q <= ovf_d;
      end
   end
   // stage 2 is combinational: the FIFO register itself is the second pipeline stage
   assign f.push = v_q & ~clr;
   assign f.data_in = y;
   assign f.flush = clr;
   assign f.ready = dout_ready;
   jt49_dcrm_fifo u_fifo(.clk(clk), .rst(rst), .s(f.slave));
   assign dout = f.data_out;
   assign dout_valid = f.valid;
   assign ovf_cnt = ovf_q;
endmodule

// File: tb/tb_jt49_dcrm.sv
// tb_jt49_dcrm: directed scoreboard bench for jt49_dcrm.
module tb_jt49_dcrm;
   import jt49_pkg::*;
   logic clk = 0, rst = 1, din_stb = 0, clr = 0;
   logic [9:0] din = 0;
   logic [2:0] gain = 0;
   logic [7:0] ovf;
   int checks = 0, errors = 0;
   logic signed [15:0] q[$];
   int m_avg = 0;
   bit m_init = 1;
   jt49_dcrm_if bus();
   always #5 clk = ~clk;
   jt49_dcrm #(.SHIFT(8), .DW(10)) dut(
      .clk(clk), .rst(rst), .din(din), .din_stb(din_stb), .gain(gain), .clr(clr),
      .dout(bus.data_out), .dout_valid(bus.valid), .dout_ready(bus.ready), .ovf_cnt(ovf));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [15:0] sat(input int v);
      return v > 32767 ? 16'sh7fff : v < -32768 ? 16'sh8000 : 16'(v);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic stb(input int x, input bit keep);
      int dd;
      if (m_init) begin
         dd = 0;
         m_avg = x * 256;
         m_init = 0;
      end else begin
         dd = x - m_avg / 256;
         m_avg = m_avg + x - m_avg / 256;
      end
      if (keep) q.push_back(sat(dd * (1 << (5 + int'(gain)))));
      din = 10'(x);
      din_stb = 1;
      tick(1);
      din_stb = 0;
   endtask

   task automatic do_clr();
      clr = 1;
      tick(1);
      clr = 0;
      m_init = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
      chk("drain", q.size(), 0);
      tick(1);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.valid && bus.ready) begin
         chk("q_nonempty", int'(q.size() > 0), 1);
         if (q.size() > 0) chk("dout", bus.data_out, q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.ready = 1;
      tick(3);
      chk("rst_valid", bus.valid, 0);
      chk("rst_dout", bus.data_out, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_state", dut.state_q, INIT);
      rst = 0;
      tick(1);
      stb(512, 1);
      chk("lat1_valid", bus.valid, 0);
      tick(1);
      chk("lat2_valid", bus.valid, 1);
      chk("state_run", dut.state_q, RUN);
      drain();
      stb(612, 1);
      drain();
      stb(400, 1);
      stb(800, 1);
      stb(512, 1);
      drain();
      gain = 3;
      do_clr();
      stb(0, 1);
      stb(1023, 1);
      drain();
      do_clr();
      stb(1023, 1);
      stb(0, 1);
      drain();
      gain = 0;
      do_clr();
      bus.ready = 0;
      stb(100, 1);
      stb(200, 1);
      stb(300, 0);
      tick(3);
      chk("ovf_one", ovf, 1);
      chk("full_valid", bus.valid, 1);
      chk("head", bus.data_out, q[0]);
      stb(400, 1);
      bus.ready = 1;
      drain();
      chk("pushpop_ovf", ovf, 1);
      chk("empty_valid", bus.valid, 0);
      chk("empty_dout", bus.data_out, 0);
      bus.ready = 0;
      stb(10, 1);
      stb(20, 1);
      for (int i = 0; i < 298; i++) stb(30 + i, 0);
      tick(3);
      chk("ovf_sat", ovf, 255);
      bus.ready = 1;
      drain();
      stb(500, 0);
      clr = 1;
      tick(1);
      clr = 0;
      m_init = 1;
      chk("clr_valid", bus.valid, 0);
      tick(3);
      chk("clr_valid_later", bus.valid, 0);
      chk("clr_ovf_kept", ovf, 255);
      stb(700, 1);
      drain();
      din = 100;
      din_stb = 1;
      clr = 1;
      tick(1);
      din_stb = 0;
      clr = 0;
      m_init = 1;
      chk("stbclr_state", dut.state_q, INIT);
      stb(300, 1);
      drain();
      bus.ready = 0;
      stb(50, 0);
      stb(60, 0);
      rst = 1;
      tick(1);
      rst = 0;
      m_init = 1;
      chk("midrst_valid", bus.valid, 0);
      chk("midrst_ovf", ovf, 0);
      tick(3);
      chk("midrst_valid_later", bus.valid, 0);
      bus.ready = 1;
      stb(200, 1);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
